// File: rtl/genius_pkg.sv
// Shared definitions for the Genius game controller: state encodings and the
// default inter-round pause length.
package genius_pkg;

  typedef enum logic [2:0] {
    ST_INIT       = 3'd0,
    ST_SETUP      = 3'd1,
    ST_SEQUENCE   = 3'd2,
    ST_PLAY       = 3'd3,
    ST_CHECK      = 3'd4,
    ST_NEXT_ROUND = 3'd5,
    ST_RESULT     = 3'd6,
    ST_PAUSE      = 3'd7
  } state_t;

  // 0.5 s at 50 MHz
  localparam int unsigned PAUSE_CYCLES_DEFAULT = 32'd25_000_000;

endpackage

// File: rtl/pause_timer.sv
// Inter-round pause counter; only exists when GENIUS_ROUND_PAUSE_EN is defined.
// done rises on the last of PAUSE_CYCLES consecutive cycles with start high.
`ifdef GENIUS_ROUND_PAUSE_EN
module pause_timer
  import genius_pkg::*;
#(
  parameter int unsigned PAUSE_CYCLES = PAUSE_CYCLES_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  output logic done
);

  // A zero-length request degenerates to a single pause cycle.
  localparam int unsigned LAST  = (PAUSE_CYCLES > 0) ? PAUSE_CYCLES - 1 : 0;
  localparam int          CNT_W = (LAST > 0) ? $clog2(LAST + 1) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign done = start && (cnt_q == CNT_W'(LAST));

  always_comb begin
    cnt_d = '0;
    if (start && !done) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/game_controller.sv
// Moore control FSM for the Genius memory game. Define GENIUS_ROUND_PAUSE_EN
// to insert a PAUSE_CYCLES-long idle state between rounds.
module game_controller
  import genius_pkg::*;
#(
  parameter int unsigned PAUSE_CYCLES = PAUSE_CYCLES_DEFAULT
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       enter,
  input  logic       end_FPGA,
  input  logic       end_User,
  input  logic       end_time,
  input  logic       win,
  input  logic       match,
  output logic       R1,
  output logic       R2,
  output logic       E1,
  output logic       E2,
  output logic       E3,
  output logic       E4,
  output logic       SEL,
  output logic [2:0] state_o
);

  state_t state_q, state_d;
  logic   enter_q;
  logic   enter_rise;

  // A held key must advance the FSM only once.
  assign enter_rise = enter && !enter_q;

`ifdef GENIUS_ROUND_PAUSE_EN
  logic pause_run;
  logic pause_done;

  assign pause_run = (state_q == ST_PAUSE);

  pause_timer #(
    .PAUSE_CYCLES(PAUSE_CYCLES)
  ) u_pause_timer (
    .clock(CLOCK_50),
    .reset(reset),
    .start(pause_run),
    .done (pause_done)
  );
`else
  // Pause length only matters when the pause state is built in.
  logic unused_pause_cycles;
  assign unused_pause_cycles = ^PAUSE_CYCLES;
`endif

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= ST_INIT;
      enter_q <= 1'b0;
    end else begin
      state_q <= state_d;
      enter_q <= enter;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:     state_d = ST_SETUP;
      ST_SETUP:    if (enter_rise) state_d = ST_SEQUENCE;
      ST_SEQUENCE: if (end_FPGA) state_d = ST_PLAY;
      ST_PLAY: begin
        if (end_User) begin
          state_d = ST_CHECK;
        end else if (end_time) begin
          state_d = ST_RESULT;
        end
      end
      ST_CHECK:    state_d = (match && !win) ? ST_NEXT_ROUND : ST_RESULT;
`ifdef GENIUS_ROUND_PAUSE_EN
      ST_NEXT_ROUND: state_d = ST_PAUSE;
      ST_PAUSE:      if (pause_done) state_d = ST_SEQUENCE;
`else
      ST_NEXT_ROUND: state_d = ST_SEQUENCE;
`endif
      ST_RESULT:   if (enter_rise) state_d = ST_INIT;
      // Encoding 7 lands here when the pause state is not built in.
      default:     state_d = ST_INIT;
    endcase
  end

  always_comb begin
    R1  = 1'b0;
    R2  = 1'b0;
    E1  = 1'b0;
    E2  = 1'b0;
    E3  = 1'b0;
    E4  = 1'b0;
    SEL = 1'b0;
    case (state_q)
      ST_INIT: begin
        R1 = 1'b1;
        R2 = 1'b1;
      end
      ST_SETUP:    E1 = 1'b1;
      ST_SEQUENCE: E3 = 1'b1;
      ST_PLAY:     E2 = 1'b1;
      ST_NEXT_ROUND: begin
        E4 = 1'b1;
        R2 = 1'b1;
      end
      ST_RESULT:   SEL = 1'b1;
      default: ;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_game_controller.sv
// Self-checking bench for game_controller: expected states are queued as each
// stimulus cycle is driven and compared, with the decoded outputs, after the edge.
`timescale 1ns/1ps
module tb_game_controller;

  localparam logic [5:0] IN_NONE  = 6'b000000;
  localparam logic [5:0] IN_ENTER = 6'b100000;
  localparam logic [5:0] IN_FPGA  = 6'b010000;
  localparam logic [5:0] IN_USER  = 6'b001000;
  localparam logic [5:0] IN_TIME  = 6'b000100;
  localparam logic [5:0] IN_WIN   = 6'b000010;
  localparam logic [5:0] IN_MATCH = 6'b000001;

  localparam logic [2:0] S_INIT = 3'd0, S_SETUP = 3'd1, S_SEQ = 3'd2, S_PLAY = 3'd3,
                         S_CHECK = 3'd4, S_NEXT = 3'd5, S_RESULT = 3'd6, S_PAUSE = 3'd7;

  logic       clk = 1'b0;
  logic       reset, enter, end_FPGA, end_User, end_time, win, match;
  logic       R1, R2, E1, E2, E3, E4, SEL;
  logic [2:0] state_o;

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];

  always #5 clk = ~clk;

  game_controller #(
    .PAUSE_CYCLES(4)
  ) dut (
    .CLOCK_50(clk),
    .reset   (reset),
    .enter   (enter),
    .end_FPGA(end_FPGA),
    .end_User(end_User),
    .end_time(end_time),
    .win     (win),
    .match   (match),
    .R1      (R1),
    .R2      (R2),
    .E1      (E1),
    .E2      (E2),
    .E3      (E3),
    .E4      (E4),
    .SEL     (SEL),
    .state_o (state_o)
  );

  // Output vector {R1,R2,E1,E2,E3,E4,SEL} each state must present.
  function automatic logic [6:0] exp_outs(input logic [2:0] st);
    case (st)
      S_INIT:   return 7'b1100000;
      S_SETUP:  return 7'b0010000;
      S_SEQ:    return 7'b0000100;
      S_PLAY:   return 7'b0001000;
      S_NEXT:   return 7'b0100010;
      S_RESULT: return 7'b0000001;
      default:  return 7'b0000000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_now(input string tag, input logic [2:0] exp_st);
    check({tag, "_state"}, {5'b0, state_o}, {5'b0, exp_st});
    check({tag, "_outs"}, {1'b0, R1, R2, E1, E2, E3, E4, SEL}, {1'b0, exp_outs(exp_st)});
  endtask

  task automatic step(input logic [5:0] in, input logic [2:0] exp_st);
    logic [2:0] e;
    {enter, end_FPGA, end_User, end_time, win, match} = in;
    exp_q.push_back(exp_st);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("queue_empty", 8'd0, 8'd1);
    end else begin
      e = exp_q.pop_front();
      check_now("step", e);
    end
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_now("reset", S_INIT);
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  // From just after reset release, walk to NEXT_ROUND.
  task automatic to_next_round();
    step(IN_NONE, S_SETUP);
    step(IN_ENTER, S_SEQ);
    step(IN_FPGA, S_PLAY);
    step(IN_USER | IN_MATCH, S_CHECK);
    step(IN_MATCH, S_NEXT);
  endtask

  initial begin
    reset = 1'b1;
    {enter, end_FPGA, end_User, end_time, win, match} = IN_NONE;
    #2;
    check_now("por", S_INIT);
    @(posedge clk);
    #2;
    reset = 1'b0;

    // Full round: INIT, SETUP, SEQUENCE, PLAY, CHECK, NEXT_ROUND
    step(IN_NONE, S_SETUP);
    step(IN_NONE, S_SETUP);
    step(IN_ENTER, S_SEQ);
    step(IN_NONE, S_SEQ);
    step(IN_FPGA, S_PLAY);
    step(IN_NONE, S_PLAY);
    step(IN_USER | IN_MATCH, S_CHECK);
    step(IN_MATCH, S_NEXT);
`ifdef GENIUS_ROUND_PAUSE_EN
    for (int i = 0; i < 4; i++) step(IN_NONE, S_PAUSE);
    step(IN_NONE, S_SEQ);
`else
    step(IN_NONE, S_SEQ);
`endif

    // Timeout in PLAY, then restart from RESULT
    step(IN_FPGA, S_PLAY);
    step(IN_TIME, S_RESULT);
    step(IN_NONE, S_RESULT);
    step(IN_ENTER, S_INIT);
    step(IN_ENTER, S_SETUP);

    // enter still high from RESULT: no edge in SETUP until it drops and rises
    step(IN_ENTER, S_SETUP);
    step(IN_NONE, S_SETUP);
    // Held enter for 10 cycles advances exactly once
    step(IN_ENTER, S_SEQ);
    for (int i = 0; i < 9; i++) step(IN_ENTER, S_SEQ);

    // end_User beats end_time; mismatch goes to RESULT
    step(IN_FPGA, S_PLAY);
    step(IN_USER | IN_TIME, S_CHECK);
    step(IN_NONE, S_RESULT);
    step(IN_ENTER, S_INIT);
    step(IN_NONE, S_SETUP);

    // Final round reached goes to RESULT
    step(IN_ENTER, S_SEQ);
    step(IN_FPGA, S_PLAY);
    step(IN_USER, S_CHECK);
    step(IN_MATCH | IN_WIN, S_RESULT);
    step(IN_ENTER, S_INIT);

    // Asynchronous abort from PLAY
    step(IN_NONE, S_SETUP);
    step(IN_ENTER, S_SEQ);
    step(IN_FPGA, S_PLAY);
    apply_reset();

`ifdef GENIUS_ROUND_PAUSE_EN
    // Abort on the 2nd PAUSE cycle, then a full-length pause afterwards
    to_next_round();
    step(IN_NONE, S_PAUSE);
    step(IN_NONE, S_PAUSE);
    apply_reset();
    to_next_round();
    for (int i = 0; i < 4; i++) step(IN_NONE, S_PAUSE);
    step(IN_NONE, S_SEQ);
`else
    // Abort straight out of NEXT_ROUND
    to_next_round();
    apply_reset();
    step(IN_NONE, S_SETUP);
`endif

    check("queue_drained", 8'(exp_q.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
